output_display_driver: RTL and testbench

- Consumer end of the SAP-1 output port. Takes the 8-bit value held by the output register (`display` bus) and shows it as decimal on three multiplexed 7-segment digits.
- Converts binary to BCD with a sequential double-dabble engine, one shift per clock.
- Scans hundreds, tens and ones digits with a refresh divider and blanks leading zeros.
- Sits between the output register and the board's seven-segment pins.

---
 rtl/output_display_driver.sv | 220 ++++++++++++++++++++++
 tb/tb_output_display_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : output_display_driver
// Purpose  : Shows the 8-bit SAP-1 output register value as decimal on three
//            multiplexed seven-segment digits. A sequential double-dabble
//            engine converts binary to BCD (one shift per clock). A refresh
//            divider scans hundreds/tens/ones, and leading zeros are blanked.
// Ports    : CLK      - system clock, rising edge
//            nCLR     - asynchronous active-low clear
//            display  - unsigned value from the output register
//            seg      - segment drive {g,f,e,d,c,b,a}
//            an       - digit enables: [0] ones, [1] tens, [2] hundreds
//            bcd      - last completed conversion {hundreds, tens, ones}
//            busy     - high while a conversion is in progress
// Revision : 1.0 - initial release
// ============================================================================
module output_display_driver #(
  parameter int REFRESH_DIV = 16,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        CLK,
  input  logic        nCLR,
  input  logic [7:0]  display,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int                 c_DIV_W   = $clog2(REFRESH_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(REFRESH_DIV - 1);
  localparam logic [6:0]         c_SEG_OFF = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [2:0]         c_AN_OFF  = ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Conversion state
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [19:0] r_shift;
  logic [2:0]  r_iter;
  logic [7:0]  r_last;
  logic        r_force;
  logic [11:0] r_bcd;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [19:0] w_shift_nxt;
  logic [2:0]  w_iter_nxt;
  logic [7:0]  w_last_nxt;
  logic        w_force_nxt;
  logic [11:0] w_bcd_nxt;
  logic        w_busy_nxt;

  logic [19:0] w_adj;
  logic [19:0] w_stepped;

  // One double-dabble step: correct every BCD nibble that would overflow past
  // 9 after doubling, then shift the whole register left by one.
  always_comb begin
    w_adj        = r_shift;
    if (r_shift[19:16] >= 4'd5) w_adj[19:16] = r_shift[19:16] + 4'd3;
    if (r_shift[15:12] >= 4'd5) w_adj[15:12] = r_shift[15:12] + 4'd3;
    if (r_shift[11:8]  >= 4'd5) w_adj[11:8]  = r_shift[11:8]  + 4'd3;
    w_stepped    = {w_adj[18:0], 1'b0};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_iter_nxt  = r_iter;
    w_last_nxt  = r_last;
    w_force_nxt = r_force;
    w_bcd_nxt   = r_bcd;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        // force makes the first edge after reset convert even if the input
        // happens to equal the cleared last-captured value.
        if ((display != r_last) || r_force) begin
          w_shift_nxt = {12'b0, display};
          w_last_nxt  = display;
          w_force_nxt = 1'b0;
          w_iter_nxt  = 3'd0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // display is deliberately not looked at here; a change is picked up
        // by the mismatch test on the next IDLE edge.
        w_shift_nxt = w_stepped;
        w_iter_nxt  = r_iter + 3'd1;
        if (r_iter == 3'd7) begin
          w_bcd_nxt   = w_stepped[19:8];
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      r_state <= S_IDLE;
      r_shift <= 20'd0;
      r_iter  <= 3'd0;
      r_last  <= 8'd0;
      r_force <= 1'b1;
      r_bcd   <= 12'h000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_iter  <= w_iter_nxt;
      r_last  <= w_last_nxt;
      r_force <= w_force_nxt;
      r_bcd   <= w_bcd_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Digit scan
  // --------------------------------------------------------------------------
  logic [c_DIV_W-1:0] r_div;
  logic [1:0]         r_dig;
  logic [6:0]         r_seg;
  logic [2:0]         r_an;

  logic               w_div_wrap;
  logic [3:0]         w_nib;
  logic               w_blank;
  logic [2:0]         w_an_al;
  logic [6:0]         w_seg_al;
  logic [6:0]         w_seg_drv;
  logic [2:0]         w_an_drv;

  assign w_div_wrap = (r_div == c_DIV_MAX);

  // Select the nibble and blanking for the digit being scanned (active-low
  // enable pattern). Index 3 never occurs; it is treated as blanked.
  always_comb begin
    w_nib   = r_bcd[3:0];
    w_blank = 1'b0;
    w_an_al = 3'b111;
    case (r_dig)
      2'd0: begin
        w_nib   = r_bcd[3:0];
        w_an_al = 3'b110;
      end
      2'd1: begin
        w_nib   = r_bcd[7:4];
        w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
        w_an_al = 3'b101;
      end
      2'd2: begin
        w_nib   = r_bcd[11:8];
        w_blank = (r_bcd[11:8] == 4'd0);
        w_an_al = 3'b011;
      end
      default: begin
        w_blank = 1'b1;
      end
    endcase
    if (w_blank) w_an_al = 3'b111;
  end

  // Active-low segment codes {g..a}; out-of-range nibbles show nothing.
  always_comb begin
    w_seg_al = 7'b1111111;
    if (!w_blank) begin
      case (w_nib)
        4'd0:    w_seg_al = 7'b1000000;
        4'd1:    w_seg_al = 7'b1111001;
        4'd2:    w_seg_al = 7'b0100100;
        4'd3:    w_seg_al = 7'b0110000;
        4'd4:    w_seg_al = 7'b0011001;
        4'd5:    w_seg_al = 7'b0010010;
        4'd6:    w_seg_al = 7'b0000010;
        4'd7:    w_seg_al = 7'b1111000;
        4'd8:    w_seg_al = 7'b0000000;
        4'd9:    w_seg_al = 7'b0010000;
        default: w_seg_al = 7'b1111111;
      endcase
    end
  end

  assign w_seg_drv = ACTIVE_LOW ? w_seg_al : ~w_seg_al;
  assign w_an_drv  = ACTIVE_LOW ? w_an_al  : ~w_an_al;

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      r_div <= '0;
      r_dig <= 2'd0;
      r_seg <= c_SEG_OFF;
      r_an  <= c_AN_OFF;
    end else begin
      r_div <= w_div_wrap ? '0 : r_div + 1'b1;
      if (w_div_wrap) r_dig <= (r_dig == 2'd2) ? 2'd0 : r_dig + 2'd1;
      r_seg <= w_seg_drv;
      r_an  <= w_an_drv;
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign bcd  = r_bcd;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_output_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_display_driver
// Purpose  : Self-checking bench. Two instances (common-anode, divide-by-4 and
//            common-cathode, divide-by-3) share the inputs and are compared
//            each cycle against a decimal/cycle-count reference model, plus
//            vector tables and directed corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_display_driver;

  logic        CLK = 1'b0;
  logic        nCLR;
  logic [7:0]  display;
  logic [6:0]  segA, segB;
  logic [2:0]  anA, anB;
  logic [11:0] bcdA, bcdB;
  logic        busyA, busyB;

  always #5 CLK = ~CLK;

  output_display_driver #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_a (
    .CLK(CLK), .nCLR(nCLR), .display(display),
    .seg(segA), .an(anA), .bcd(bcdA), .busy(busyA)
  );

  output_display_driver #(.REFRESH_DIV(3), .ACTIVE_LOW(1'b0)) u_dut_b (
    .CLK(CLK), .nCLR(nCLR), .display(display),
    .seg(segB), .an(anB), .bcd(bcdB), .busy(busyB)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Active-low pattern for scan slot 'dig' showing value b.
  function automatic void exp_out(input int dig, input logic [11:0] b,
                                  output logic [6:0] s, output logic [2:0] a);
    int h, t, o;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    s = 7'b1111111;
    a = 3'b111;
    if (dig == 0) begin
      s = seg_code(o); a = 3'b110;
    end else if (dig == 1) begin
      if (h != 0 || t != 0) begin s = seg_code(t); a = 3'b101; end
    end else begin
      if (h != 0) begin s = seg_code(h); a = 3'b011; end
    end
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  int          m_cyc   = 0;
  bit          m_busy  = 1'b0;
  int          m_left  = 0;
  int          m_val   = 0;
  int          m_last  = 0;
  bit          m_force = 1'b1;
  logic [11:0] m_bcd   = 12'h000;
  logic [6:0]  mA_seg  = 7'b1111111;
  logic [2:0]  mA_an   = 3'b111;
  logic [6:0]  mB_seg  = 7'b0000000;
  logic [2:0]  mB_an   = 3'b000;
  logic [6:0]  t_s;
  logic [2:0]  t_a;

  always @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      m_cyc = 0; m_busy = 1'b0; m_left = 0; m_last = 0; m_force = 1'b1;
      m_bcd = 12'h000;
      mA_seg = 7'b1111111; mA_an = 3'b111;
      mB_seg = 7'b0000000; mB_an = 3'b000;
    end else begin
      // Outputs reflect the scan slot and bcd held before this edge.
      exp_out((m_cyc / 4) % 3, m_bcd, t_s, t_a);
      mA_seg = t_s;  mA_an = t_a;
      exp_out((m_cyc / 3) % 3, m_bcd, t_s, t_a);
      mB_seg = ~t_s; mB_an = ~t_a;
      if (!m_busy) begin
        if (int'(display) != m_last || m_force) begin
          m_val = int'(display); m_last = m_val; m_force = 1'b0;
          m_busy = 1'b1; m_left = 8;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_bcd  = to_bcd(m_val);
        end
      end
      m_cyc++;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_bcdA",  32'(bcdA),  32'(m_bcd));
      chk("model_bcdB",  32'(bcdB),  32'(m_bcd));
      chk("model_busyA", 32'(busyA), 32'(m_busy));
      chk("model_busyB", 32'(busyB), 32'(m_busy));
      chk("model_segA",  32'(segA),  32'(mA_seg));
      chk("model_anA",   32'(anA),   32'(mA_an));
      chk("model_segB",  32'(segB),  32'(mB_seg));
      chk("model_anB",   32'(anB),   32'(mB_an));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  disp;
    int          hold;
    logic [11:0] exp_bcd;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    vecs[0] = '{8'd7,   12, 12'h007};
    vecs[1] = '{8'd105, 12, 12'h105};
    vecs[2] = '{8'd0,   10, 12'h000};
    vecs[3] = '{8'd9,   10, 12'h009};
    vecs[4] = '{8'd10,  10, 12'h010};
    vecs[5] = '{8'd99,  10, 12'h099};
    vecs[6] = '{8'd100, 10, 12'h100};
    vecs[7] = '{8'd128, 10, 12'h128};
    vecs[8] = '{8'd255, 10, 12'h255};
    vecs[9] = '{8'd200, 10, 12'h200};

    nCLR    = 1'b0;
    display = 8'hFF;
    repeat (2) step();
    chk_en = 1'b1;

    // Reset state
    chk("rst_bcd",  32'(bcdA),  32'h000);
    chk("rst_busy", 32'(busyA), 32'd0);
    chk("rst_segA", 32'(segA),  32'h7F);
    chk("rst_anA",  32'(anA),   32'h7);
    chk("rst_segB", 32'(segB),  32'h00);
    chk("rst_anB",  32'(anB),   32'h0);

    // First conversion after release: 8'hFF
    nCLR = 1'b1;
    step();
    chk("e1_busy", 32'(busyA), 32'd1);
    repeat (7) step();
    chk("e8_busy", 32'(busyA), 32'd1);
    chk("e8_bcd",  32'(bcdA),  32'h000);
    step();
    chk("e9_bcd",  32'(bcdA),  32'h255);
    chk("e9_busy", 32'(busyA), 32'd0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      display = vecs[i].disp;
      repeat (vecs[i].hold) step();
      chk("vec_bcdA",  32'(bcdA),  32'(vecs[i].exp_bcd));
      chk("vec_bcdB",  32'(bcdB),  32'(vecs[i].exp_bcd));
      chk("vec_busy",  32'(busyA), 32'd0);
    end

    // Input changing mid-conversion, then held
    display = 8'd1; repeat (2) step();
    display = 8'd3; repeat (2) step();
    display = 8'd5; repeat (18) step();
    chk("conv_bcdA", 32'(bcdA), 32'h005);
    chk("conv_bcdB", 32'(bcdB), 32'h005);

    // Reset in the middle of converting 200
    display = 8'd200;
    step();
    chk("mid_busy", 32'(busyA), 32'd1);
    repeat (4) step();
    nCLR = 1'b0;
    #1;
    chk("abort_bcd",  32'(bcdA),  32'h000);
    chk("abort_busy", 32'(busyA), 32'd0);
    chk("abort_anA",  32'(anA),   32'h7);
    chk("abort_segA", 32'(segA),  32'h7F);
    chk("abort_anB",  32'(anB),   32'h0);
    repeat (2) step();
    nCLR = 1'b1;
    repeat (8) step();
    chk("rel8_bcd",  32'(bcdA),  32'h000);
    chk("rel8_busy", 32'(busyA), 32'd1);
    step();
    chk("rel9_bcd",  32'(bcdA),  32'h200);

    // Steady input: no further conversions
    repeat (50) begin
      step();
      chk("hold_busy", 32'(busyA), 32'd0);
      chk("hold_bcd",  32'(bcdA),  32'h200);
    end

    // Randomized input sequence
    repeat (150) begin
      display = 8'($urandom);
      repeat ($urandom_range(1, 20)) step();
    end
    repeat (12) step();
    chk("rand_final_bcd", 32'(bcdA), 32'(to_bcd(int'(display))));

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
